// File: rtl/adder_share_pkg.sv
// ---------------------------------------------------------------------------
// adder_share_pkg
// Shared types and helpers for the adder-sharing controller.
//   state_t   : controller FSM states
//   MAX_NREQ  : largest supported requester count (sets pointer width)
//   PTR_W     : width of requester indices / round-robin pointer
//   next_rr() : round-robin successor of a requester index, wrapping at n
// ---------------------------------------------------------------------------
package adder_share_pkg;

  localparam int MAX_NREQ = 8;
  localparam int PTR_W    = $clog2(MAX_NREQ);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_SUM = 2'd2,
    RETURN   = 2'd3
  } state_t;

  // Index following ptr among n requesters, wrapping n-1 -> 0.
  function automatic logic [PTR_W-1:0] next_rr(input logic [PTR_W-1:0] ptr, input int n);
    logic [PTR_W-1:0] res;
    if (int'(ptr) >= n - 1) res = '0;
    else                    res = ptr + PTR_W'(1);
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// ---------------------------------------------------------------------------
// rr_arbiter_core
// Purely combinational round-robin pick: the first asserted request at or
// after ptr, searching upward and wrapping from NREQ-1 back to 0.
// Ports:
//   req      in  NREQ   request vector
//   ptr      in  PTR_W  highest-priority index this cycle (< NREQ)
//   grantOh  out NREQ   one-hot grant (zero when no request)
//   grantIdx out PTR_W  index of the granted requester
//   anyReq   out 1      at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter_core
  import adder_share_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grantOh,
  output logic [PTR_W-1:0] grantIdx,
  output logic             anyReq
);

  // Each requester's distance from ptr in wrap-around order; the requesting
  // index with the smallest distance wins.
  always_comb begin
    int bestDist;
    // NOTE: every variable written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    grantOh  = '0;
    grantIdx = '0;
    anyReq   = 1'b0;
    bestDist = NREQ;
    for (int j = 0; j < NREQ; j++) begin
      if (req[j] && (((j + NREQ - int'(ptr)) % NREQ) < bestDist)) begin
        bestDist = (j + NREQ - int'(ptr)) % NREQ;
        grantIdx = PTR_W'(j);
        anyReq   = 1'b1;
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      grantOh[j] = anyReq && (grantIdx == PTR_W'(j));
    end
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// ---------------------------------------------------------------------------
// adder_share_ctrl
// Shares one handshaked adder (A,B -> SUM) among NREQ requesters. A requester
// is picked round-robin, its operands are issued, the sum is awaited and then
// returned to that requester only. A watchdog aborts a sum that never comes.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  per-requester operand handshake (req_ready one-hot)
//   req_a, req_b         operands, requester i at [i*WIDTH +: WIDTH]
//   add_valid/add_ready  operand pair to the adder, add_a/add_b payload
//   sum_valid/sum_ready  result from the adder, sum_in payload
//   rsp_valid/rsp_ready  per-requester result handshake, rsp_sum shared bus
//   busy                 a transaction is in flight
//   err                  sticky watchdog flag, cleared only by reset
// ---------------------------------------------------------------------------
module adder_share_ctrl
  import adder_share_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  add_valid,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  input  logic                  add_ready,
  input  logic                  sum_valid,
  input  logic [WIDTH-1:0]      sum_in,
  output logic                  sum_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_sum,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic                  busy,
  output logic                  err
);

  localparam int WD_W = $clog2(TIMEOUT);

  state_t             state, stateNext;
  logic [PTR_W-1:0]   rrPtr, grantReg, arbIdx;
  logic [NREQ-1:0]    grantOhReg, arbOh;
  logic               arbAny;
  logic [WIDTH-1:0]   aReg, bReg, sumReg, selA, selB;
  logic [WD_W-1:0]    wdCnt;
  logic               errReg;
  logic               accept, rspTaken, wdExpire;

  rr_arbiter_core #(.NREQ(NREQ)) u_arb (
    .req      (req_valid),
    .ptr      (rrPtr),
    .grantOh  (arbOh),
    .grantIdx (arbIdx),
    .anyReq   (arbAny)
  );

  // Operands of the winning requester (arbOh is one-hot or zero).
  always_comb begin
    selA = '0;
    selB = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arbOh[i]) begin
        selA = req_a[i*WIDTH +: WIDTH];
        selB = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign accept   = (state == IDLE) && arbAny;
  assign rspTaken = (state == RETURN) && |(rsp_ready & grantOhReg);
  // The last allowed WAIT_SUM cycle passes without a sum.
  assign wdExpire = (state == WAIT_SUM) && !sum_valid && (wdCnt == WD_W'(TIMEOUT - 1));

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:     if (arbAny) stateNext = ISSUE;
      ISSUE:    if (add_ready) stateNext = WAIT_SUM;
      WAIT_SUM: begin
        if (sum_valid)     stateNext = RETURN;
        else if (wdExpire) stateNext = IDLE;
      end
      RETURN:   if (rspTaken) stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  // NOTE: sequential state is assigned with non-blocking assignments only, so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // NOTE: the operand/result latches feed outputs directly, so they are reset
  // along with the control state to present all-zero outputs after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrPtr      <= '0;
      grantReg   <= '0;
      grantOhReg <= '0;
      aReg       <= '0;
      bReg       <= '0;
      sumReg     <= '0;
      wdCnt      <= '0;
      errReg     <= 1'b0;
    end else begin
      if (accept) begin
        aReg       <= selA;
        bReg       <= selB;
        grantReg   <= arbIdx;
        grantOhReg <= arbOh;
      end
      if (state == ISSUE && add_ready) wdCnt <= '0;
      if (state == WAIT_SUM) begin
        if (sum_valid)      sumReg <= sum_in;
        else if (wdExpire)  errReg <= 1'b1;
        else                wdCnt  <= wdCnt + WD_W'(1);
      end
      // A completed or aborted transaction both hand priority onward.
      if (rspTaken || wdExpire) rrPtr <= next_rr(grantReg, NREQ);
    end
  end

  // req_ready is the accept strobe of the IDLE cycle; held low during reset
  // so that pending requests cannot be taken while rst_n is asserted.
  assign req_ready = (accept && rst_n) ? arbOh : '0;
  assign add_valid = (state == ISSUE);
  assign add_a     = aReg;
  assign add_b     = bReg;
  assign sum_ready = (state == WAIT_SUM);
  assign rsp_valid = (state == RETURN) ? grantOhReg : '0;
  assign rsp_sum   = sumReg;
  assign busy      = (state != IDLE);
  assign err       = errReg;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// ---------------------------------------------------------------------------
// tb_adder_share_ctrl
// Directed bench for adder_share_ctrl with a transaction-level model that is
// compared against the DUT outputs every cycle, a small adder responder, and
// literal expectations for each scenario.
// ---------------------------------------------------------------------------
module tb_adder_share_ctrl;

  localparam int NREQ    = 4;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 16;
  localparam int TOTW    = NREQ * WIDTH;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [TOTW-1:0] req_a, req_b;
  logic            add_valid, add_ready, sum_ready, busy, err;
  logic            sum_valid = 1'b0;
  logic [WIDTH-1:0] add_a, add_b, rsp_sum;
  logic [WIDTH-1:0] sum_in = '0;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  adder_share_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .add_valid(add_valid), .add_a(add_a), .add_b(add_b), .add_ready(add_ready),
    .sum_valid(sum_valid), .sum_in(sum_in), .sum_ready(sum_ready),
    .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_ready(rsp_ready),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ohIdx(input logic [NREQ-1:0] v);
    logic [NREQ-1:0] t;
    for (int i = 0; i < NREQ; i++) begin
      t = v >> i;
      if (t[0]) return i;
    end
    return -1;
  endfunction

  // First requesting index at or after ptr, wrapping.
  function automatic int rrPick(input logic [NREQ-1:0] v, input int ptr);
    logic [NREQ-1:0] t;
    for (int k = 0; k < NREQ; k++) begin
      t = v >> ((ptr + k) % NREQ);
      if (t[0]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // ---------------- adder responder ----------------
  bit adderStall = 0;
  bit lateSum    = 0;
  logic [WIDTH-1:0] lateVal = '0;
  bit addFireS, sumFireS, pend;
  logic [WIDTH-1:0] capA, capB, pendSum = '0;

  always @(negedge clk) begin
    addFireS = add_valid && add_ready;
    sumFireS = sum_valid && sum_ready;
    capA     = add_a;
    capB     = add_b;
  end

  always @(posedge clk) begin
    #1;
    if (!rst_n) pend = 0;
    else begin
      if (sumFireS) pend = 0;
      if (addFireS && !adderStall) begin
        pend    = 1;
        pendSum = capA + capB;
      end
    end
    sum_valid = (pend && !adderStall) || lateSum;
    sum_in    = lateSum ? lateVal : pendSum;
  end

  // ---------------- model, compare and monitor ----------------
  typedef struct { int idx; int sum; int cyc; } rsp_t;
  rsp_t rspQ[$];
  int   grantQ[$];
  int   acceptCyc   = 0;
  int   sumReadyCnt = 0;
  logic [NREQ-1:0] reqFireS = '0;

  // Model: mStage 0 = no transaction, 1 = operands offered to adder,
  // 2 = awaiting sum, 3 = result offered to requester.
  int mStage = 0, mIdx = 0, mPtr = 0, mWait = 0;
  bit mErr = 0;
  logic [WIDTH-1:0] mA = '0, mB = '0, mSum = '0;

  task automatic modelCycle();
    int pick;
    logic [NREQ-1:0] expReady, expRsp, t;
    pick     = rrPick(req_valid, mPtr);
    expReady = (mStage == 0 && pick >= 0) ? NREQ'(1 << pick) : '0;
    expRsp   = (mStage == 3) ? NREQ'(1 << mIdx) : '0;
    check("req_ready", req_ready, expReady);
    check("busy", busy, mStage != 0);
    check("add_valid", add_valid, mStage == 1);
    if (mStage == 1) begin
      check("add_a", add_a, mA);
      check("add_b", add_b, mB);
    end
    check("sum_ready", sum_ready, mStage == 2);
    check("rsp_valid", rsp_valid, expRsp);
    if (mStage == 3) check("rsp_sum", rsp_sum, mSum);
    check("err", err, mErr);
    // advance to the state after the coming rising edge
    case (mStage)
      0: if (pick >= 0) begin
        mIdx = pick;
        mA = WIDTH'(req_a >> (pick * WIDTH));
        mB = WIDTH'(req_b >> (pick * WIDTH));
        mStage = 1;
      end
      1: if (add_ready) begin mStage = 2; mWait = 0; end
      2: if (sum_valid) begin
        mSum = sum_in;
        mStage = 3;
      end else begin
        mWait++;
        if (mWait == TIMEOUT) begin
          mErr = 1; mStage = 0; mPtr = (mIdx + 1) % NREQ;
        end
      end
      3: begin
        t = rsp_ready >> mIdx;
        if (t[0]) begin mStage = 0; mPtr = (mIdx + 1) % NREQ; end
      end
      default: mStage = 0;
    endcase
  endtask

  always @(negedge clk) begin
    reqFireS = req_valid & req_ready;
    if (!rst_n) begin
      mStage = 0; mPtr = 0; mWait = 0; mErr = 0;
    end else begin
      if (|(req_valid & req_ready)) begin
        grantQ.push_back(ohIdx(req_valid & req_ready));
        acceptCyc = cyc;
      end
      if (|(rsp_valid & rsp_ready))
        rspQ.push_back('{ohIdx(rsp_valid & rsp_ready), int'(rsp_sum), cyc});
      if (sum_ready) sumReadyCnt++;
      modelCycle();
    end
  end

  // ---------------- stimulus helpers ----------------
  bit constReq = 0;

  // Advance to 2 time units after the next rising edge(s); requesters drop
  // valid after acceptance unless they are re-requesting continuously.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
      if (!constReq) req_valid = req_valid & ~reqFireS;
    end
  endtask

  task automatic setReq(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [TOTW-1:0] m;
    m         = TOTW'({WIDTH{1'b1}}) << (i * WIDTH);
    req_a     = (req_a & ~m) | (TOTW'(a) << (i * WIDTH));
    req_b     = (req_b & ~m) | (TOTW'(b) << (i * WIDTH));
    req_valid = req_valid | (NREQ'(1) << i);
  endtask

  task automatic clearLogs();
    rspQ.delete();
    grantQ.delete();
    sumReadyCnt = 0;
  endtask

  task automatic doReset();
    @(posedge clk); #2;
    rst_n = 1'b0; req_valid = '0; constReq = 0; adderStall = 0; lateSum = 0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic waitRsp(input string name, input int n, input int budget);
    int k = 0;
    while (rspQ.size() < n && k < budget) begin
      step(1);
      k++;
    end
    check(name, rspQ.size() >= n, 1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int expOrder[5];
    int expSum[5];
    expOrder = '{0, 1, 2, 3, 0};
    expSum   = '{1, 12, 23, 34, 1};
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    add_ready = 1'b1; rsp_ready = '1;
    repeat (3) @(posedge clk);
    #2;
    // reset values
    check("rst req_ready", req_ready, 0);
    check("rst add_valid", add_valid, 0);
    check("rst add_a", add_a, 0);
    check("rst add_b", add_b, 0);
    check("rst sum_ready", sum_ready, 0);
    check("rst rsp_valid", rsp_valid, 0);
    check("rst rsp_sum", rsp_sum, 0);
    check("rst busy", busy, 0);
    check("rst err", err, 0);
    rst_n = 1'b1;
    step(1);

    // 1: single request, zero-wait adder
    clearLogs();
    setReq(0, 8'd3, 8'd4);
    waitRsp("t1 response", 1, 20);
    if (rspQ.size() >= 1) begin
      check("t1 rsp idx", rspQ[0].idx, 0);
      check("t1 rsp sum", rspQ[0].sum, 7);
      check("t1 accept-to-rsp cycles", rspQ[0].cyc - acceptCyc, 3);
    end
    check("t1 busy after", busy, 0);

    // 2: all four requesting continuously from reset
    doReset();
    clearLogs();
    constReq = 1;
    for (int i = 0; i < NREQ; i++) setReq(i, WIDTH'(10 * i + 1), WIDTH'(i));
    waitRsp("t2 responses", 5, 60);
    constReq = 0;
    req_valid = '0;
    check("t2 grant count", grantQ.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < rspQ.size()) begin
        check("t2 grant order", grantQ[i], expOrder[i]);
        check("t2 rsp idx", rspQ[i].idx, expOrder[i]);
        check("t2 rsp sum", rspQ[i].sum, expSum[i]);
      end
    end
    step(1);

    // 3: wrap-around sum, busy across the transaction
    clearLogs();
    setReq(2, 8'd200, 8'd100);
    step(1);
    check("t3 busy during", busy, 1);
    waitRsp("t3 response", 1, 20);
    if (rspQ.size() >= 1) begin
      check("t3 rsp idx", rspQ[0].idx, 2);
      check("t3 rsp sum", rspQ[0].sum, 44);
    end
    check("t3 busy after", busy, 0);

    // 4: adder never returns a sum -> watchdog abort, then normal service
    clearLogs();
    adderStall = 1;
    setReq(1, 8'd5, 8'd6);
    for (int k = 0; k < 60 && err !== 1'b1; k++) step(1);
    check("t4 err set", err, 1);
    check("t4 wait cycles", sumReadyCnt, TIMEOUT);
    check("t4 busy after abort", busy, 0);
    check("t4 no response", rspQ.size(), 0);
    adderStall = 0;
    setReq(3, 8'd1, 8'd2);
    waitRsp("t4 next response", 1, 20);
    if (rspQ.size() >= 1) begin
      check("t4 next idx", rspQ[0].idx, 3);
      check("t4 next sum", rspQ[0].sum, 3);
    end
    check("t4 err sticky", err, 1);

    // 5: requester backpressure; non-granted rsp_ready ignored
    clearLogs();
    rsp_ready = 4'b0010;
    setReq(0, 8'd9, 8'd8);
    setReq(1, 8'd1, 8'd1);
    for (int k = 0; k < 20 && rsp_valid == '0; k++) step(1);
    for (int k = 0; k < 10; k++) begin
      check("t5 rsp_valid held", rsp_valid, 4'b0001);
      check("t5 rsp_sum held", rsp_sum, 17);
      check("t5 no new grant", req_ready, 0);
      step(1);
    end
    rsp_ready = '1;
    waitRsp("t5 responses", 2, 30);
    if (rspQ.size() >= 2) begin
      check("t5 first idx", rspQ[0].idx, 0);
      check("t5 first sum", rspQ[0].sum, 17);
      check("t5 second idx", rspQ[1].idx, 1);
      check("t5 second sum", rspQ[1].sum, 2);
    end

    // 6: reset while awaiting the sum; a late sum is ignored
    clearLogs();
    adderStall = 1;
    setReq(2, 8'd4, 8'd4);
    for (int k = 0; k < 20 && sum_ready !== 1'b1; k++) step(1);
    check("t6 in wait", sum_ready, 1);
    step(3);
    #1;
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    check("t6 req_ready", req_ready, 0);
    check("t6 add_valid", add_valid, 0);
    check("t6 sum_ready", sum_ready, 0);
    check("t6 rsp_valid", rsp_valid, 0);
    check("t6 rsp_sum", rsp_sum, 0);
    check("t6 busy", busy, 0);
    check("t6 err cleared", err, 0);
    step(1);
    lateSum = 1; lateVal = 8'd99; adderStall = 0;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1);
      check("t6 late sum_ready", sum_ready, 0);
      check("t6 late rsp_valid", rsp_valid, 0);
      check("t6 late busy", busy, 0);
    end
    lateSum = 0;
    step(2);
    check("t6 no response", rspQ.size(), 0);
    check("t6 err after", err, 0);

    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", checks);
    $fatal(1);
  end

endmodule
